// File: rtl/spi_mem_arbiter_if.sv
// Bus bundle for the SPI/host/RAM arbiter.
// Direction-grouped modports: slave is the arbiter, master drives it.
interface spi_mem_arbiter_if #(
    parameter int AddrBits = 12
);
    logic [AddrBits-1:0] spiAddr;
    logic [7:0]          spiWData;
    logic                spiWE;
    logic                spiRE;
    logic [7:0]          spiRData;
    logic                spiRValid;

    logic                hostReq;
    logic                hostWE;
    logic [AddrBits-1:0] hostAddr;
    logic [7:0]          hostWData;
    logic                hostReady;
    logic                hostAck;
    logic [7:0]          hostRData;
    logic                hostStarved;

    logic                memEN;
    logic                memWE;
    logic [AddrBits-1:0] memAddr;
    logic [7:0]          memWData;
    logic [7:0]          memRData;

    modport slave (
        input  spiAddr, spiWData, spiWE, spiRE,
        output spiRData, spiRValid,
        input  hostReq, hostWE, hostAddr, hostWData,
        output hostReady, hostAck, hostRData, hostStarved,
        output memEN, memWE, memAddr, memWData,
        input  memRData
    );

    modport master (
        output spiAddr, spiWData, spiWE, spiRE,
        input  spiRData, spiRValid,
        output hostReq, hostWE, hostAddr, hostWData,
        input  hostReady, hostAck, hostRData, hostStarved,
        input  memEN, memWE, memAddr, memWData,
        output memRData
    );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Single-port byte RAM shared by SPI (never stalled, top priority)
// and a host port using pulse request / pulse acknowledge.
module spi_mem_arbiter #(
    parameter int AddrBits = 12,
    parameter int MaxWait  = 64
) (
    input logic               SysClk,
    input logic               Reset,
    spi_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;

    localparam logic [8:0] MaxW = 9'(MaxWait);

    state_t              state;
    logic                cap_we;
    logic [AddrBits-1:0] cap_addr;
    logic [7:0]          cap_wdata;
    logic [7:0]          wait_cnt;
    logic                starved;
    logic                spi_rv;

    logic                spi_acc;
    logic                issue_live;
    logic                issue_cap;
    logic [8:0]          wait_inc;

    assign spi_acc    = (bus.spiWE | bus.spiRE) & ~Reset;
    assign issue_live = (state == IDLE) & bus.hostReq & ~spi_acc & ~Reset;
    assign issue_cap  = (state == PEND) & ~spi_acc & ~Reset;
    assign wait_inc   = {1'b0, wait_cnt} + 9'd1;

    // SPI owns the RAM whenever it strobes; host fills free cycles only
    always_comb begin
        bus.memEN    = 1'b0;
        bus.memWE    = 1'b0;
        bus.memAddr  = '0;
        bus.memWData = '0;
        unique case (1'b1)
            spi_acc: begin
                bus.memEN    = 1'b1;
                bus.memWE    = bus.spiWE;
                bus.memAddr  = bus.spiAddr;
                bus.memWData = bus.spiWData;
            end
            issue_live: begin
                bus.memEN    = 1'b1;
                bus.memWE    = bus.hostWE;
                bus.memAddr  = bus.hostAddr;
                bus.memWData = bus.hostWData;
            end
            issue_cap: begin
                bus.memEN    = 1'b1;
                bus.memWE    = cap_we;
                bus.memAddr  = cap_addr;
                bus.memWData = cap_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            state     <= IDLE;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            wait_cnt  <= '0;
            starved   <= 1'b0;
            spi_rv    <= 1'b0;
        end else begin
            spi_rv <= bus.spiRE & ~bus.spiWE;
            unique case (state)
                IDLE: begin
                    if (bus.hostReq) begin
                        cap_we    <= bus.hostWE;
                        cap_addr  <= bus.hostAddr;
                        cap_wdata <= bus.hostWData;
                        state     <= spi_acc ? PEND : RESP;
                    end
                end
                PEND: begin
                    if (!spi_acc) begin
                        state    <= RESP;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt != 8'hFF) wait_cnt <= wait_inc[7:0];
                        // diagnostic only: the request stays queued
                        if (wait_inc >= MaxW) starved <= 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hostReady   = (state == IDLE) & ~Reset;
    assign bus.hostAck     = (state == RESP) & ~Reset;
    assign bus.hostRData   = bus.hostAck ? bus.memRData : 8'h00;
    assign bus.spiRValid   = spi_rv & ~Reset;
    assign bus.spiRData    = bus.spiRValid ? bus.memRData : 8'h00;
    assign bus.hostStarved = starved;
endmodule
